// File: rtl/mem_access_ctrl.sv
// Load/store sequencer between the MEM stage and a req/ack single-port data RAM.
// Optional ack timeout enabled by defining MEM_TIMEOUT_EN.
module mem_access_ctrl #(
    parameter int ADDR_W = 32
`ifdef MEM_TIMEOUT_EN
    , parameter int MAX_WAIT = 255
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [1:0]        mem_size_i,
    input  logic              mem_sign_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [31:0]       mem_wdata_i,
    output logic              ram_req_o,
    output logic              ram_we_o,
    output logic [3:0]        ram_sel_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [31:0]       ram_wdata_o,
    input  logic [31:0]       ram_rdata_i,
    input  logic              ram_ack_i,
    output logic [31:0]       rdata_o,
    output logic              done_o,
    output logic              stall_req_o,
    output logic              misalign_o,
    output logic              bus_err_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              ram_req_q, ram_req_d;
    logic              ram_we_q, ram_we_d;
    logic [3:0]        ram_sel_q, ram_sel_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [31:0]       ram_wdata_q, ram_wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [1:0]        size_q, size_d;
    logic              sign_q, sign_d;
    logic [1:0]        lane_q, lane_d;

    logic              aligned;
    logic [3:0]        sel_new;
    logic [31:0]       wdata_new;

`ifdef MEM_TIMEOUT_EN
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       bus_err_q, bus_err_d;
`endif

    // Extract the addressed lane from the RAM word and extend it to 32 bits.
    function automatic logic [31:0] format_load(input logic [31:0] data,
                                                input logic [1:0]  size,
                                                input logic [1:0]  lane,
                                                input logic        sign);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = data[{lane, 3'b000} +: 8];
        h = lane[1] ? data[31:16] : data[15:0];
        case (size)
            2'b00:   res = {{24{sign & b[7]}}, b};
            2'b01:   res = {{16{sign & h[15]}}, h};
            default: res = data;
        endcase
        return res;
    endfunction

    // NOTE: every signal assigned in an always_comb gets a default first so no latch is inferred.
    always_comb begin
        aligned   = 1'b1;
        sel_new   = 4'b1111;
        wdata_new = mem_wdata_i;
        case (mem_size_i)
            2'b00: begin
                sel_new   = 4'b0001 << mem_addr_i[1:0];
                wdata_new = {4{mem_wdata_i[7:0]}};
            end
            2'b01: begin
                aligned   = ~mem_addr_i[0];
                sel_new   = mem_addr_i[1] ? 4'b1100 : 4'b0011;
                wdata_new = {2{mem_wdata_i[15:0]}};
            end
            default: aligned = (mem_addr_i[1:0] == 2'b00);
        endcase
    end

    always_comb begin
        state_d     = state_q;
        ram_req_d   = ram_req_q;
        ram_we_d    = ram_we_q;
        ram_sel_d   = ram_sel_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        rdata_d     = rdata_q;
        size_d      = size_q;
        sign_d      = sign_q;
        lane_d      = lane_q;
`ifdef MEM_TIMEOUT_EN
        wait_cnt_d  = wait_cnt_q;
        bus_err_d   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (mem_req_i && aligned) begin
                    ram_req_d   = 1'b1;
                    ram_we_d    = mem_we_i;
                    ram_sel_d   = sel_new;
                    ram_addr_d  = {mem_addr_i[ADDR_W-1:2], 2'b00};
                    ram_wdata_d = wdata_new;
                    size_d      = mem_size_i;
                    sign_d      = mem_sign_i;
                    lane_d      = mem_addr_i[1:0];
                    state_d     = ST_WAIT;
`ifdef MEM_TIMEOUT_EN
                    wait_cnt_d  = 8'd0;
`endif
                end
            end
            ST_WAIT: begin
                // An ack coinciding with the timeout limit completes normally.
                if (ram_ack_i) begin
                    ram_req_d = 1'b0;
                    rdata_d   = ram_we_q ? 32'h0 : format_load(ram_rdata_i, size_q, lane_q, sign_q);
                    state_d   = ST_DONE;
                end
`ifdef MEM_TIMEOUT_EN
                else if (wait_cnt_q == WAIT_LAST) begin
                    ram_req_d = 1'b0;
                    rdata_d   = 32'h0;
                    bus_err_d = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
`endif
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ram_req_q   <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_sel_q   <= 4'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= 32'h0;
            rdata_q     <= 32'h0;
            size_q      <= 2'b00;
            sign_q      <= 1'b0;
            lane_q      <= 2'b00;
        end else begin
            state_q     <= state_d;
            ram_req_q   <= ram_req_d;
            ram_we_q    <= ram_we_d;
            ram_sel_q   <= ram_sel_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            rdata_q     <= rdata_d;
            size_q      <= size_d;
            sign_q      <= sign_d;
            lane_q      <= lane_d;
        end
    end

`ifdef MEM_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_q <= 8'd0;
            bus_err_q  <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            bus_err_q  <= bus_err_d;
        end
    end
    assign bus_err_o = bus_err_q;
`else
    assign bus_err_o = 1'b0;
`endif

    assign ram_req_o   = ram_req_q;
    assign ram_we_o    = ram_we_q;
    assign ram_sel_o   = ram_sel_q;
    assign ram_addr_o  = ram_addr_q;
    assign ram_wdata_o = ram_wdata_q;
    assign rdata_o     = rdata_q;
    assign done_o      = (state_q == ST_DONE);
    assign stall_req_o = (state_q == ST_WAIT) || (state_q == ST_IDLE && mem_req_i && aligned);
    assign misalign_o  = (state_q == ST_IDLE) && mem_req_i && !aligned;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed cases followed by random accesses
// compared against an arithmetic reference model. Covers the timeout when MEM_TIMEOUT_EN is defined.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic [1:0]  mem_size = 2'b00;
    logic        mem_sign = 1'b0;
    logic [31:0] mem_addr = 32'h0;
    logic [31:0] mem_wdata = 32'h0;
    logic [31:0] ram_rdata = 32'h0;
    logic        ram_ack = 1'b0;

    logic        ram_req_o, ram_we_o, done_o, stall_req_o, misalign_o, bus_err_o;
    logic [3:0]  ram_sel_o;
    logic [31:0] ram_addr_o, ram_wdata_o, rdata_o;

    int checks = 0;
    int errors = 0;

    mem_access_ctrl #(
        .ADDR_W(32)
`ifdef MEM_TIMEOUT_EN
        , .MAX_WAIT(4)
`endif
    ) dut (
        .clk(clk), .rst(rst),
        .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_size_i(mem_size),
        .mem_sign_i(mem_sign), .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata),
        .ram_req_o(ram_req_o), .ram_we_o(ram_we_o), .ram_sel_o(ram_sel_o),
        .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o),
        .ram_rdata_i(ram_rdata), .ram_ack_i(ram_ack),
        .rdata_o(rdata_o), .done_o(done_o), .stall_req_o(stall_req_o),
        .misalign_o(misalign_o), .bus_err_o(bus_err_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "simulation did not finish");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: access width in bytes (reserved size behaves as a word).
    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] size, input logic sign,
                                               input logic [31:0] addr, input logic [31:0] rdata);
        longint n, v;
        n = nbytes(size);
        v = (longint'(rdata) >> (8 * (addr % 4))) & ((64'd1 << (8 * n)) - 1);
        if (sign && n < 4 && v >= (64'd1 << (8 * n - 1)))
            v = v - (64'd1 << (8 * n));
        return 32'(v);
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] size, input logic [31:0] wdata);
        longint n, v;
        n = nbytes(size);
        v = longint'(wdata) & ((64'd1 << (8 * n)) - 1);
        if (n == 1) v = v * 64'h01010101;
        else if (n == 2) v = v * 64'h00010001;
        return 32'(v);
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_ram_req"}, 32'(ram_req_o), 32'h0);
        check({tag, "_ram_we"}, 32'(ram_we_o), 32'h0);
        check({tag, "_ram_sel"}, 32'(ram_sel_o), 32'h0);
        check({tag, "_ram_addr"}, ram_addr_o, 32'h0);
        check({tag, "_ram_wdata"}, ram_wdata_o, 32'h0);
        check({tag, "_rdata"}, rdata_o, 32'h0);
        check({tag, "_done"}, 32'(done_o), 32'h0);
        check({tag, "_stall"}, 32'(stall_req_o), 32'h0);
        check({tag, "_misalign"}, 32'(misalign_o), 32'h0);
        check({tag, "_bus_err"}, 32'(bus_err_o), 32'h0);
    endtask

    // One complete access; ack is returned in WAIT cycle number 'delay'.
    task automatic do_access(input string tag, input logic we, input logic [1:0] size,
                             input logic sign, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] rdata, input int delay);
        int          n;
        logic        ok;
        logic [31:0] e_sel, e_addr, e_wdata, e_rdata;
        n       = nbytes(size);
        ok      = (addr % n) == 0;
        e_sel   = ((32'd1 << n) - 1) << (addr % 4);
        e_addr  = addr - (addr % 4);
        e_wdata = model_wdata(size, wdata);
        e_rdata = we ? 32'h0 : model_load(size, sign, addr, rdata);

        @(negedge clk);
        mem_req = 1'b1; mem_we = we; mem_size = size; mem_sign = sign;
        mem_addr = addr; mem_wdata = wdata;
        #1;
        check({tag, "_misalign"}, 32'(misalign_o), 32'(!ok));
        check({tag, "_stall_req"}, 32'(stall_req_o), 32'(ok));
        @(posedge clk); #1;
        if (!ok) begin
            mem_req = 1'b0;
            #1;
            check({tag, "_no_ram_req"}, 32'(ram_req_o), 32'h0);
            check({tag, "_no_stall"}, 32'(stall_req_o), 32'h0);
            check({tag, "_no_done"}, 32'(done_o), 32'h0);
            return;
        end
        // Pipeline is stalled: scramble inputs, they must have no effect.
        mem_req = 1'(($urandom_range(0, 1)));
        mem_we = 1'($urandom_range(0, 1)); mem_size = 2'($urandom_range(0, 3));
        mem_addr = $urandom; mem_wdata = $urandom;
        for (int i = 1; i <= delay; i++) begin
            @(negedge clk);
            ram_ack = (i == delay);
            ram_rdata = (i == delay) ? rdata : $urandom;
            #1;
            check({tag, "_ram_req"}, 32'(ram_req_o), 32'h1);
            check({tag, "_ram_we"}, 32'(ram_we_o), 32'(we));
            check({tag, "_ram_sel"}, 32'(ram_sel_o), e_sel);
            check({tag, "_ram_addr"}, ram_addr_o, e_addr);
            check({tag, "_ram_wdata"}, ram_wdata_o, e_wdata);
            check({tag, "_stall_wait"}, 32'(stall_req_o), 32'h1);
            check({tag, "_done_early"}, 32'(done_o), 32'h0);
            @(posedge clk); #1;
            ram_ack = 1'b0;
        end
        check({tag, "_done"}, 32'(done_o), 32'h1);
        check({tag, "_stall_done"}, 32'(stall_req_o), 32'h0);
        check({tag, "_ram_req_drop"}, 32'(ram_req_o), 32'h0);
        check({tag, "_rdata"}, rdata_o, e_rdata);
        check({tag, "_bus_err"}, 32'(bus_err_o), 32'h0);
        // A request still visible in DONE belongs to the finished instruction.
        mem_req = 1'b1; mem_size = 2'd2; mem_addr = 32'h200;
        @(posedge clk); #1;
        mem_req = 1'b0;
        check({tag, "_idle_no_req"}, 32'(ram_req_o), 32'h0);
        check({tag, "_idle_no_done"}, 32'(done_o), 32'h0);
    endtask

    initial begin
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        do_access("word_load", 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 2);
        check("word_load_value", rdata_o, 32'hDEADBEEF);
        do_access("byte_signed", 1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 32'h80112233, 1);
        check("byte_signed_value", rdata_o, 32'hFFFFFF80);
        do_access("byte_unsigned", 1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 32'h80112233, 3);
        check("byte_unsigned_value", rdata_o, 32'h00000080);
        do_access("half_store", 1'b1, 2'd1, 1'b0, 32'h0E, 32'h0000ABCD, 32'h12345678, 2);
        do_access("half_load_hi", 1'b0, 2'd1, 1'b1, 32'h22, 32'h0, 32'h9ABC1234, 1);
        do_access("misalign_word", 1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 32'h0, 1);
        do_access("misalign_half", 1'b1, 2'd1, 1'b0, 32'h101, 32'h55, 32'h0, 1);
        do_access("reserved_size", 1'b0, 2'd3, 1'b1, 32'h44, 32'h0, 32'hCAFEF00D, 4);

        for (int i = 0; i < 40; i++) begin
            do_access("rand", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
                      $urandom_range(1, 4));
        end

        // Reset in WAIT aborts the access; a late ack must be ignored.
        @(negedge clk);
        mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'd2; mem_addr = 32'h300;
        @(posedge clk); #1;
        mem_req = 1'b0;
        check("abort_ram_req", 32'(ram_req_o), 32'h1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_all_zero("abort_reset");
        @(negedge clk);
        rst = 1'b0;
        ram_ack = 1'b1; ram_rdata = 32'h13579BDF;
        @(posedge clk); #1;
        ram_ack = 1'b0;
        check_all_zero("late_ack");
        @(posedge clk); #1;
        check("late_ack_no_done", 32'(done_o), 32'h0);

`ifdef MEM_TIMEOUT_EN
        @(negedge clk);
        mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'd2; mem_addr = 32'h40;
        @(posedge clk); #1;
        mem_req = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            check("timeout_ram_req", 32'(ram_req_o), 32'h1);
            check("timeout_no_done", 32'(done_o), 32'h0);
            @(posedge clk); #1;
        end
        check("timeout_ram_req_drop", 32'(ram_req_o), 32'h0);
        check("timeout_done", 32'(done_o), 32'h1);
        check("timeout_bus_err", 32'(bus_err_o), 32'h1);
        check("timeout_rdata", rdata_o, 32'h0);
        @(posedge clk); #1;
        check("timeout_bus_err_pulse", 32'(bus_err_o), 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Sequences load/store accesses issued by the MEM pipeline stage onto a single-port data RAM that uses a req/ack handshake.
- Generates byte-lane selects, formats load data (shift plus sign/zero extension), and raises a stall request to the pipeline controller until the access completes.
- Sits between the MEM stage and the data RAM.
- Its result (rdata_o, qualified by done_o) muxes into the MEM-stage ans path before the MEM/WB register.

Parameters:
- ADDR_W, 32, data RAM address width (byte address).
- MAX_WAIT, 255, cycle limit for the ack timeout. Used only with MEM_TIMEOUT_EN; 8-bit counter.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-high (rst_enable = 1)
- mem_req_i  in  1  MEM stage holds a load/store this cycle
- mem_we_i  in  1  1 = store, 0 = load
- mem_size_i  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved (treated as word)
- mem_sign_i  in  1  1 = sign-extend load, 0 = zero-extend
- mem_addr_i  in  ADDR_W  byte address
- mem_wdata_i  in  32  store data, right-aligned
- ram_req_o  out  1  RAM request, registered
- ram_we_o  out  1  RAM write enable, registered
- ram_sel_o  out  4  byte-lane enables, registered
- ram_addr_o  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00}), registered
- ram_wdata_o  out  32  lane-replicated store data, registered
- ram_rdata_i  in  32  RAM read data, valid with ram_ack_i
- ram_ack_i  in  1  RAM completion, one-cycle pulse
- rdata_o  out  32  formatted load data, registered
- done_o  out  1  one-cycle completion strobe
- stall_req_o  out  1  stall request to pipeline controller
- misalign_o  out  1  misaligned-access flag (combinational)
- bus_err_o  out  1  timeout error (registered, one cycle)

Behaviour:
- Reset (async, any state): state = IDLE; all registered outputs = 0. rdata_o = 32'h0. An ack arriving after reset is ignored.
- Alignment rule: half requires addr[0] = 0; word requires addr[1:0] = 0. Otherwise the access is misaligned.
- Little-endian lane mapping:
  - byte: sel = 1 << addr[1:0]
  - half: sel = addr[1] ? 1100 : 0011
  - word: sel = 1111
- Store data replication: byte replicated ×4; half replicated ×2; word unchanged.
- State IDLE:
  - If mem_req_i is high and the access is aligned: stall_req_o = 1 (combinational); latch the RAM outputs, size, sign and addr[1:0]; ram_req_o = 1 from the next cycle; go to WAIT.
  - If mem_req_i is high and the access is misaligned: misalign_o = 1; no RAM access; stall_req_o = 0; remain IDLE.
- State WAIT:
  - stall_req_o = 1; ram_* outputs held stable.
  - On ram_ack_i: clear ram_req_o; register rdata_o (load: select lane by latched addr[1:0]/size, then extend per sign; store: 0); go to DONE.
- State DONE:
  - done_o = 1; stall_req_o = 0, so the pipeline advances at the end of this cycle.
  - Unconditionally go to IDLE. mem_req_i seen in DONE belongs to the finished instruction and is ignored.
- Latency: request seen in cycle T; ram_req_o high at T+1; ack at T+k; done_o at T+k+1. Minimum total is 3 cycles (k = 1, ack in the first request cycle).
- Ack outside WAIT is ignored.
- Inputs in WAIT are ignored (the pipeline is stalled).
- Reset asserted in WAIT aborts the access; the RAM must tolerate ram_req_o dropping.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - An 8-bit counter clears on entry to WAIT and increments each WAIT cycle without ack.
  - When it reaches MAX_WAIT: drop ram_req_o, go to DONE with bus_err_o = 1 and rdata_o = 0.
  - Ack in the same cycle as the limit wins (normal completion).
- MEM_TIMEOUT_EN undefined: WAIT persists until ack; bus_err_o tied to 0; no counter logic.

Test Plan:
- Word load, addr 0x100, RAM returns 0xDEADBEEF with ack at the 2nd req cycle -> stall high 3 cycles, ram_sel 1111, done_o and rdata_o = 0xDEADBEEF in the 4th cycle.
- Signed byte load, addr 0x103, rdata 0x80112233 -> sel 1000, rdata_o = 0xFFFFFF80; the same access unsigned -> 0x00000080.
- Half store, addr 0x0E, wdata 0x0000ABCD -> ram_we 1, sel 1100, ram_wdata 0xABCDABCD, ram_addr 0x0C; done_o after ack.
- Word load at addr 0x102 -> misalign_o = 1 the same cycle, ram_req_o never asserted, stall_req_o = 0.
- Reset pulsed in WAIT, then a late ack -> all outputs 0, state IDLE, no done_o.
- With MEM_TIMEOUT_EN and MAX_WAIT = 4, no ack -> ram_req_o drops after 4 WAIT cycles, next cycle done_o = 1, bus_err_o = 1, rdata_o = 0.
